// File: rtl/ro_enc_gen.sv
// ro_enc_gen: quadrature rotary-encoder waveform generator driven by detent commands
module ro_enc_gen #(
    parameter int P_PHASE_CLKS = 1000,
    parameter int P_CNT_W      = 8,
    parameter int P_POS_W      = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_cmd_dir,
    input  logic [P_CNT_W-1:0] i_cmd_cnt,
    input  logic               i_abort,
    output logic               o_enc_a,
    output logic               o_enc_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [P_POS_W-1:0] o_pos
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PH1  = 2'd1;
    localparam logic [1:0] S_REST = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int DW = $clog2(P_PHASE_CLKS);
    localparam logic [DW-1:0] DW_LAST = DW'(P_PHASE_CLKS - 1);

    logic [1:0]         r_state;
    logic [DW-1:0]      r_dwell;
    logic [P_CNT_W-1:0] r_rem;
    logic               r_dir;
    logic               r_abort;
    logic               r_a;
    logic               r_b;
    logic [P_POS_W-1:0] r_pos;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         w_nxt;
    logic               w_dwell_end;
    logic               w_abort;
    logic               w_first;
    logic               w_second;
    logic               w_fdir;
    logic               w_tog_a;
    logic               w_tog_b;

    // Next-state logic; an abort seen on the final REST edge also ends the command
    always_comb begin
        w_dwell_end = r_dwell == DW_LAST;
        w_abort     = r_abort | i_abort;
        w_nxt       = r_state;
        case (r_state)
            S_IDLE: w_nxt = i_cmd_valid ? ((i_cmd_cnt == '0) ? S_DONE : S_PH1) : S_IDLE;
            S_PH1:  w_nxt = w_dwell_end ? S_REST : S_PH1;
            S_REST: w_nxt = w_dwell_end ? ((r_rem != '0 && !w_abort) ? S_PH1 : S_DONE) : S_REST;
            default: w_nxt = S_IDLE;
        endcase
        w_first  = (r_state == S_IDLE && i_cmd_valid && i_cmd_cnt != '0) || (r_state == S_REST && w_nxt == S_PH1);
        w_second = r_state == S_PH1 && w_dwell_end;
        w_fdir   = (r_state == S_IDLE) ? i_cmd_dir : r_dir;
        w_tog_a  = (w_first && w_fdir) || (w_second && !r_dir);
        w_tog_b  = (w_first && !w_fdir) || (w_second && r_dir);
    end

    // State, dwell timing, A/B toggling and position tracking
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_dwell <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_abort <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_pos   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_ready <= w_nxt == S_IDLE;
            r_busy  <= w_nxt == S_PH1 || w_nxt == S_REST;
            r_done  <= w_nxt == S_DONE;
            r_a     <= r_a ^ w_tog_a;
            r_b     <= r_b ^ w_tog_b;
            r_dwell <= (w_nxt != r_state || r_state == S_IDLE) ? '0 : (r_state == S_REST && i_abort) ? DW_LAST : r_dwell + 1'b1;
            if (r_state == S_IDLE && i_cmd_valid) begin
                r_dir <= i_cmd_dir;
                r_rem <= i_cmd_cnt;
            end
            if (r_state == S_DONE)
                r_abort <= 1'b0;
            else if ((r_state == S_PH1 || r_state == S_REST) && i_abort)
                r_abort <= 1'b1;
            if (w_second) begin
                r_pos <= r_dir ? r_pos + 1'b1 : r_pos - 1'b1;
                r_rem <= r_rem - 1'b1;
            end
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_enc_a     = r_a;
    assign o_enc_b     = r_b;
    assign o_pos       = r_pos;
endmodule

// File: tb/tb_ro_enc_gen.sv
// tb_ro_enc_gen: directed vector bench for the rotary-encoder generator
module tb_ro_enc_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] cnt = 8'd0;
    logic       abort = 1'b0;
    logic       ready, enc_a, enc_b, busy, done;
    logic [3:0] pos;
    int         n_cmp = 0;
    int         n_fail = 0;

    typedef struct {
        logic       dir;
        int         cnt;
        int         ab_k;
        logic       hold;
        int         done_k;
        logic [3:0] pos;
        logic [1:0] ab;
    } vec_t;

    vec_t tbl[9];

    ro_enc_gen #(.P_PHASE_CLKS(4), .P_CNT_W(8), .P_POS_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(ready),
        .i_cmd_dir(dir), .i_cmd_cnt(cnt), .i_abort(abort),
        .o_enc_a(enc_a), .o_enc_b(enc_b), .o_busy(busy), .o_done(done), .o_pos(pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        logic pa, pb;
        pa = enc_a;
        pb = enc_b;
        @(posedge clk);
        #1;
        if (rst) chk("ab_single_change", int'(enc_a != pa && enc_b != pb), 0);
    endtask

    task automatic issue(input logic d, input int c);
        valid = 1'b1;
        dir = d;
        cnt = 8'(c);
        step();
        valid = 1'b0;
    endtask

    task automatic run(input vec_t v, input int idx);
        int k, done_k;
        string nm;
        valid = 1'b1;
        dir = v.dir;
        cnt = 8'(v.cnt);
        abort = v.ab_k == 0;
        step();
        valid = v.hold;
        abort = 1'b0;
        k = 0;
        done_k = -1;
        while (k < 200 && done_k < 0) begin
            if (done) begin
                done_k = k;
                valid = 1'b0;
            end else begin
                abort = (k + 1 == v.ab_k);
                step();
                abort = 1'b0;
                k++;
            end
        end
        valid = 1'b0;
        nm = $sformatf("vec%0d", idx);
        chk({nm, "_done_k"}, done_k, v.done_k);
        chk({nm, "_pos"}, int'(pos), int'(v.pos));
        chk({nm, "_ab"}, int'({enc_a, enc_b}), int'(v.ab));
        chk({nm, "_busy_at_done"}, int'(busy), 0);
        step();
        chk({nm, "_ready_after"}, int'(ready), 1);
        chk({nm, "_done_cleared"}, int'(done), 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 0, -1, 1'b0, 0, 4'hF, 2'b11};
        tbl[1] = '{1'b1, 3, 2, 1'b0, 8, 4'h0, 2'b00};
        tbl[2] = '{1'b1, 3, 5, 1'b0, 6, 4'h1, 2'b11};
        tbl[3] = '{1'b1, 3, 8, 1'b0, 8, 4'h2, 2'b00};
        tbl[4] = '{1'b1, 2, 0, 1'b0, 16, 4'h4, 2'b00};
        tbl[5] = '{1'b0, 1, -1, 1'b0, 8, 4'h3, 2'b11};
        tbl[6] = '{1'b1, 4, -1, 1'b0, 32, 4'h7, 2'b11};
        tbl[7] = '{1'b1, 1, -1, 1'b1, 8, 4'h8, 2'b00};
        tbl[8] = '{1'b0, 1, -1, 1'b0, 8, 4'h7, 2'b11};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_ab", int'({enc_a, enc_b}), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pos", int'(pos), 0);
        repeat (20) step();
        chk("hold_ab", int'({enc_a, enc_b}), 0);
        chk("hold_ready", int'(ready), 1);
        chk("hold_done", int'(done), 0);
        chk("hold_pos", int'(pos), 0);

        issue(1'b1, 1);
        chk("cw1_k0_ab", int'({enc_a, enc_b}), 2'b10);
        chk("cw1_k0_busy", int'(busy), 1);
        chk("cw1_k0_ready", int'(ready), 0);
        repeat (3) step();
        chk("cw1_k3_ab", int'({enc_a, enc_b}), 2'b10);
        chk("cw1_k3_pos", int'(pos), 0);
        step();
        chk("cw1_k4_ab", int'({enc_a, enc_b}), 2'b11);
        chk("cw1_k4_pos", int'(pos), 1);
        repeat (3) step();
        chk("cw1_k7_done", int'(done), 0);
        step();
        chk("cw1_k8_done", int'(done), 1);
        chk("cw1_k8_ready", int'(ready), 0);
        step();
        chk("cw1_k9_ready", int'(ready), 1);
        chk("cw1_k9_done", int'(done), 0);

        issue(1'b0, 2);
        chk("ccw2_k0_ab", int'({enc_a, enc_b}), 2'b10);
        repeat (4) step();
        chk("ccw2_k4_ab", int'({enc_a, enc_b}), 2'b00);
        chk("ccw2_k4_pos", int'(pos), 0);
        repeat (3) step();
        chk("ccw2_k7_ab", int'({enc_a, enc_b}), 2'b00);
        step();
        chk("ccw2_k8_ab", int'({enc_a, enc_b}), 2'b01);
        repeat (4) step();
        chk("ccw2_k12_ab", int'({enc_a, enc_b}), 2'b11);
        chk("ccw2_k12_pos", int'(pos), 4'hF);
        repeat (3) step();
        chk("ccw2_k15_done", int'(done), 0);
        step();
        chk("ccw2_k16_done", int'(done), 1);
        step();
        chk("ccw2_k17_ready", int'(ready), 1);

        for (int i = 0; i < 9; i++) run(tbl[i], i);

        issue(1'b1, 2);
        chk("mid_k0_ab", int'({enc_a, enc_b}), 2'b01);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ab", int'({enc_a, enc_b}), 0);
        chk("mid_rst_ready", int'(ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        step();
        rst = 1'b1;
        step();
        run('{1'b0, 1, -1, 1'b0, 8, 4'hF, 2'b11}, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
